// File: rtl/axi_rd_scheduler.sv
// Shares one AXI AR/R port among NM read requesters, holding the grant for a whole burst.
// Define ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module axi_rd_scheduler #(
  parameter int NM   = 3,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [32*NM-1:0] rm_araddr,
  input  logic [8*NM-1:0]  rm_arlen,
  input  logic [3*NM-1:0]  rm_arsize,
  input  logic [NM-1:0]   rm_arvalid,
  output logic [NM-1:0]   rm_arready,
  output logic [31:0]     rm_rdata,
  output logic            rm_rlast,
  output logic [NM-1:0]   rm_rvalid,
  input  logic [NM-1:0]   rm_rready,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic            busy,
  output logic            err_beat
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  state_e        state_q;
  logic [GW-1:0] gnt_q;
  logic [31:0]   addr_q;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [7:0]    cnt_q;
  logic          err_q;
  logic [GW-1:0] win;
  logic          any_req;
  logic          beat;

`ifdef ARB_RR_EN
  logic [GW-1:0] ptr_q;

  // Search starts at the pointer and wraps, first requester found wins.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      idx = (int'(ptr_q) + k) % NM;
      if (!found && rm_arvalid[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (rm_arvalid[k]) win = GW'(k);
    end
  end
`endif

  assign any_req = |rm_arvalid;
  assign beat    = (state_q == R) && rvalid && rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= win;
            addr_q  <= rm_araddr[32*win +: 32];
            len_q   <= rm_arlen[8*win +: 8];
            size_q  <= rm_arsize[3*win +: 3];
            state_q <= AR;
`ifdef ARB_RR_EN
            ptr_q   <= (int'(win) == NM - 1) ? '0 : win + 1'b1;
`endif
          end
        end
        AR: begin
          if (arready) begin
            cnt_q   <= '0;
            state_q <= R;
          end
        end
        R: begin
          if (beat) begin
            cnt_q <= cnt_q + 8'd1;
            // Last beat must land exactly on arlen; any other pairing is an error.
            if (rlast) begin
              state_q <= IDLE;
              if (cnt_q != len_q) err_q <= 1'b1;
            end else if (cnt_q == len_q) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arid     = ID_W'(gnt_q);
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = size_q;
  assign arburst  = 2'b01;
  assign arvalid  = (state_q == AR);
  assign busy     = (state_q != IDLE);
  assign err_beat = err_q;

  assign rm_arready = NM'(arvalid && arready) << gnt_q;
  assign rm_rvalid  = NM'((state_q == R) && rvalid) << gnt_q;
  assign rready     = (state_q == R) && rm_rready[gnt_q];
  assign rm_rdata   = rdata;
  assign rm_rlast   = rlast;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Randomized bench for axi_rd_scheduler: bench plays requesters and AXI slave.
// Compile with ARB_RR_EN to check round-robin mode.
module tb_axi_rd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] rm_araddr;
  logic [23:0] rm_arlen;
  logic [8:0]  rm_arsize;
  logic [2:0]  rm_arvalid;
  logic [2:0]  rm_arready;
  logic [31:0] rm_rdata;
  logic        rm_rlast;
  logic [2:0]  rm_rvalid;
  logic [2:0]  rm_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        err_beat;

  axi_rd_scheduler #(.NM(3), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .rm_araddr(rm_araddr), .rm_arlen(rm_arlen), .rm_arsize(rm_arsize),
    .rm_arvalid(rm_arvalid), .rm_arready(rm_arready),
    .rm_rdata(rm_rdata), .rm_rlast(rm_rlast),
    .rm_rvalid(rm_rvalid), .rm_rready(rm_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .err_beat(err_beat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0]  pend;
  logic [31:0] a_tab [3];
  logic [7:0]  l_tab [3];
  logic [2:0]  s_tab [3];
  int  m_ptr;
  bit  m_err;
  int  order [$];

  // Reference arbiter: first pending requester scanning from ptr, wrapping.
  function automatic int pick(input logic [2:0] p, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (p[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s);
    a_tab[i] = a;
    l_tab[i] = l;
    s_tab[i] = s;
    rm_araddr[32*i +: 32] = a;
    rm_arlen[8*i +: 8]    = l;
    rm_arsize[3*i +: 3]   = s;
    pend[i] = 1'b1;
    rm_arvalid = pend;
  endtask

  // Serve the next grant: extra = beats beyond arlen+1 (negative = early rlast).
  task automatic serve(input int extra, input bit bp, input bit keep);
    int g, w, nb, tries;
    bit acc;
    g = pick(pend, m_ptr);
    rm_arvalid = pend;
    w = 0;
    do begin
      @(posedge clk); #1; w++;
    end while (!arvalid && w < 20);
    n_cmp++;
    if (!arvalid || w != 1) begin
      $display("FAIL ar_latency cycles=%0d arvalid=%b want 1 cycle", w, arvalid);
      n_bad++;
      if (!arvalid) return;
    end
    order.push_back(int'(arid));
    n_cmp++;
    if (arid !== 4'(g)) begin
      $display("FAIL arid got %0d want %0d", arid, g); n_bad++;
    end
    n_cmp++;
    if ({araddr, arlen, arsize, arburst} !== {a_tab[g], l_tab[g], s_tab[g], 2'b01}) begin
      $display("FAIL ar_fields got %h/%0d/%0d/%b want %h/%0d/%0d/01",
               araddr, arlen, arsize, arburst, a_tab[g], l_tab[g], s_tab[g]);
      n_bad++;
    end
`ifdef ARB_RR_EN
    m_ptr = (g + 1) % 3;
`endif
    repeat ($urandom_range(0, 2)) begin
      n_cmp++;
      if (rm_arready !== 3'b000 || arvalid !== 1'b1) begin
        $display("FAIL ar_wait rm_arready=%b arvalid=%b want 000/1", rm_arready, arvalid);
        n_bad++;
      end
      @(posedge clk); #1;
    end
    arready = 1'b1;
    #1;
    n_cmp++;
    if (rm_arready !== 3'(1 << g)) begin
      $display("FAIL rm_arready got %b want %b", rm_arready, 3'(1 << g)); n_bad++;
    end
    @(posedge clk); #1;
    arready = 1'b0;
    if (!keep) pend[g] = 1'b0;
    rm_arvalid = pend;
    nb = int'(l_tab[g]) + 1 + extra;
    for (int b = 0; b < nb; b++) begin
      rdata  = $urandom;
      rlast  = (b == nb - 1);
      tries  = 0;
      acc    = 1'b0;
      while (!acc && tries < 50) begin
        rvalid    = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        rm_rready = bp ? 3'($urandom_range(0, 7)) : 3'b111;
        #1;
        n_cmp++;
        if (rm_rvalid !== (rvalid ? 3'(1 << g) : 3'b000) || rm_rdata !== rdata ||
            rm_rlast !== rlast || rready !== rm_rready[g]) begin
          $display("FAIL r_fwd beat=%0d rm_rvalid=%b rdata=%h rready=%b want %b/%h/%b",
                   b, rm_rvalid, rm_rdata, rready,
                   rvalid ? 3'(1 << g) : 3'b000, rdata, rm_rready[g]);
          n_bad++;
        end
        acc = rvalid && rm_rready[g];
        @(posedge clk); #1;
        tries++;
      end
      if (!acc) begin
        n_cmp++; n_bad++;
        $display("FAIL r_timeout beat=%0d", b);
      end
      if ((rlast && b != int'(l_tab[g])) || (!rlast && b == int'(l_tab[g]))) m_err = 1'b1;
      n_cmp++;
      if (err_beat !== m_err) begin
        $display("FAIL err_beat beat=%0d got %b want %b", b, err_beat, m_err); n_bad++;
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || arvalid !== 1'b0) begin
      $display("FAIL post_burst busy=%b arvalid=%b want 0/0", busy, arvalid); n_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, arvalid, rready, err_beat, rm_arready, rm_rvalid, arid, araddr, arlen, arsize}
        !== '0) begin
      $display("FAIL reset busy=%b arvalid=%b rready=%b err=%b arid=%0d araddr=%h want all 0",
               busy, arvalid, rready, err_beat, arid, araddr);
      n_bad++;
    end
    rst = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  task automatic test_icache_burst();
    set_req(0, 32'h1FC0_0000, 8'd7, 3'd2);
    serve(0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    set_req(1, 32'h8000_1000, 8'd3, 3'd2);
    set_req(2, 32'hBFD0_0004, 8'd0, 3'd1);
    order.delete();
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    n_cmp++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 2) begin
      $display("FAIL simul_order got %p want '{1,2}", order); n_bad++;
    end
  endtask

  task automatic test_backpressure();
    set_req(1, 32'h0000_2040, 8'd5, 3'd2);
    serve(0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) || (i == 2 && pend == 3'b000))
          set_req(i, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
      end
      while (pend != 3'b000) serve(0, $urandom_range(0, 1) == 1, 1'b0);
    end
  endtask

  task automatic test_arb_order();
    int exp_order [3];
    set_req(0, 32'h100, 8'd1, 3'd2);
    set_req(1, 32'h200, 8'd1, 3'd2);
    set_req(2, 32'h300, 8'd1, 3'd2);
    order.delete();
    for (int k = 0; k < 3; k++) begin
      exp_order[k] = pick(pend, m_ptr);
      serve(0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (order.size() != 3 || order[0] != exp_order[0] || order[1] != exp_order[1] ||
        order[2] != exp_order[2]) begin
      $display("FAIL arb_order got %p want %p", order, exp_order); n_bad++;
    end
    pend = 3'b000;
    rm_arvalid = pend;
    @(posedge clk); #1;
    // A request still pending at the IDLE edge gets an AR cycle; drain it.
    if (arvalid) begin
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      rvalid = 1'b1; rlast = 1'b0; rm_rready = 3'b111;
      repeat (int'(arlen)) @(posedge clk);
      rlast = 1'b1;
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0;
    end
  endtask

  task automatic test_len_errors();
    set_req(2, 32'h0000_0800, 8'd3, 3'd2);
    serve(-1, 1'b0, 1'b0);
    set_req(1, 32'h0000_0900, 8'd3, 3'd2);
    serve(2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    set_req(0, 32'h0000_0A00, 8'd7, 3'd2);
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    pend = 3'b000;
    rm_arvalid = pend;
    rvalid = 1'b1; rm_rready = 3'b111; rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, rready, arvalid, err_beat, rm_rvalid} !== '0) begin
      $display("FAIL reset_mid busy=%b rready=%b arvalid=%b err=%b rm_rvalid=%b want 0",
               busy, rready, arvalid, err_beat, rm_rvalid);
      n_bad++;
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    rst = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    set_req(2, 32'h0000_0B00, 8'd2, 3'd0);
    serve(0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    pend = 3'b000;
    rm_araddr = '0; rm_arlen = '0; rm_arsize = '0;
    rm_arvalid = '0; rm_rready = '0;
    arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    m_ptr = 0; m_err = 1'b0;
    test_reset();
    test_icache_burst();
    test_simultaneous();
    test_backpressure();
    test_random();
    test_arb_order();
    test_len_errors();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
